// File: rtl/anf_fl_tex_block_fetch_if.sv
// Signal bundle for the ETC2 block fetcher: texel request, texture memory read port, decoder output.
// master is the surrounding system, slave is the fetcher.
interface anf_fl_tex_block_fetch_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned COORD_W = 12,
    parameter int unsigned PITCH_W = 10
);
    logic               req_valid;
    logic               req_ready;
    logic [COORD_W-1:0] req_u;
    logic [COORD_W-1:0] req_v;
    logic [ADDR_W-1:0]  req_base;
    logic [PITCH_W-1:0] req_pitch;
    logic [4:0]         req_format;
    logic               inval;
    logic               mem_req_valid;
    logic               mem_req_ready;
    logic [ADDR_W-1:0]  mem_req_addr;
    logic               mem_rsp_valid;
    logic [63:0]        mem_rsp_data;
    logic               out_valid;
    logic               out_ready;
    logic [127:0]       out_data;
    logic [4:0]         out_format;
    logic [1:0]         out_xTexel;
    logic [1:0]         out_yTexel;

    modport master (
        output req_valid, req_u, req_v, req_base, req_pitch, req_format, inval,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready,
        input  req_ready, mem_req_valid, mem_req_addr,
        input  out_valid, out_data, out_format, out_xTexel, out_yTexel
    );

    modport slave (
        input  req_valid, req_u, req_v, req_base, req_pitch, req_format, inval,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready,
        output req_ready, mem_req_valid, mem_req_addr,
        output out_valid, out_data, out_format, out_xTexel, out_yTexel
    );
endinterface

// File: rtl/anf_fl_tex_block_fetch.sv
// ETC2 block fetcher: texel (u,v) -> compressed block address, 64-bit beat fetch,
// single-entry block cache, valid/ready presentation to the decoder.
module anf_fl_tex_block_fetch #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned COORD_W       = 12,
    parameter int unsigned PITCH_W       = 10,
    parameter int unsigned ALPHA_FMT_BIT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    anf_fl_tex_block_fetch_if.slave  bus
);
    localparam int unsigned BC_W  = COORD_W - 2;
    localparam int unsigned BLK_W = BC_W + PITCH_W + 1;
    localparam int unsigned OFS_W = BLK_W + 4;
    localparam int unsigned TAG_W = ADDR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_PRESENT} state_t;

    state_t state;
    state_t state_nxt;

    logic [BC_W-1:0]   bx;
    logic [BC_W-1:0]   by;
    logic [BLK_W-1:0]  blk;
    logic [OFS_W-1:0]  ofs;
    logic              wide_c;
    logic [ADDR_W-1:0] addr_c;
    logic              hit_c;
    logic              accept;
    logic              rsp_take;
    logic              last_beat;

    logic [ADDR_W-1:0] addr_q;
    logic [4:0]        fmt_q;
    logic [1:0]        x_q;
    logic [1:0]        y_q;
    logic              beat;
    logic [127:0]      data_q;
    logic [TAG_W-1:0]  tag_q;
    logic              cache_vld;
    logic              inval_seen;

    // Block address of the incoming request, wrapping modulo 2^ADDR_W
    always_comb begin
        bx     = bus.req_u[COORD_W-1:2];
        by     = bus.req_v[COORD_W-1:2];
        wide_c = bus.req_format[ALPHA_FMT_BIT];
        blk    = BLK_W'(by) * BLK_W'(bus.req_pitch) + BLK_W'(bx);
        ofs    = wide_c ? (OFS_W'(blk) << 4) : (OFS_W'(blk) << 3);
        addr_c = bus.req_base + ADDR_W'(ofs);
    end

    always_comb begin
        hit_c     = cache_vld && (tag_q == {addr_c, wide_c}) && !bus.inval;
        accept    = (state == S_IDLE) && !rst && bus.req_valid;
        rsp_take  = (state == S_WAIT) && bus.mem_rsp_valid;
        last_beat = !fmt_q[ALPHA_FMT_BIT] || beat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (accept) state_nxt = hit_c ? S_PRESENT : S_ISSUE;
            S_ISSUE:   if (bus.mem_req_ready) state_nxt = S_WAIT;
            S_WAIT:    if (rsp_take) state_nxt = last_beat ? S_PRESENT : S_ISSUE;
            S_PRESENT: if (bus.out_ready) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready     = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.out_valid     = 1'b0;
        case (state)
            S_IDLE:    bus.req_ready     = !rst;
            S_ISSUE:   bus.mem_req_valid = 1'b1;
            S_PRESENT: bus.out_valid     = 1'b1;
            default:   ;
        endcase
        bus.mem_req_addr = addr_q + ADDR_W'({beat, 3'b000});
        bus.out_data     = data_q;
        bus.out_format   = fmt_q;
        bus.out_xTexel   = x_q;
        bus.out_yTexel   = y_q;
    end

    // data_q doubles as the cache line; a miss overwrites it, so the old entry dies at accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            fmt_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            beat       <= 1'b0;
            data_q     <= '0;
            tag_q      <= '0;
            cache_vld  <= 1'b0;
            inval_seen <= 1'b0;
        end else begin
            if (accept) begin
                addr_q     <= addr_c;
                fmt_q      <= bus.req_format;
                x_q        <= bus.req_u[1:0];
                y_q        <= bus.req_v[1:0];
                beat       <= 1'b0;
                inval_seen <= 1'b0;
                if (!hit_c) begin
                    tag_q  <= {addr_c, wide_c};
                    data_q <= '0;
                end
            end
            if ((state == S_ISSUE || state == S_WAIT) && bus.inval) begin
                inval_seen <= 1'b1;
            end
            if (rsp_take) begin
                if (beat) begin
                    data_q[127:64] <= bus.mem_rsp_data;
                end else begin
                    data_q[63:0] <= bus.mem_rsp_data;
                end
                if (!last_beat) begin
                    beat <= 1'b1;
                end
            end
            if (bus.inval || (accept && !hit_c)) begin
                cache_vld <= 1'b0;
            end else if (rsp_take && last_beat) begin
                cache_vld <= !inval_seen;
            end
        end
    end
endmodule

// File: tb/tb_anf_fl_tex_block_fetch.sv
// Randomised bench for anf_fl_tex_block_fetch: a memory responder plus a block-level
// reference model (address arithmetic, one-entry cache, per-request beat count and latency).
module tb_anf_fl_tex_block_fetch;
    logic clk;
    logic rst;

    anf_fl_tex_block_fetch_if #(.ADDR_W(32), .COORD_W(12), .PITCH_W(10)) bus ();

    anf_fl_tex_block_fetch #(
        .ADDR_W(32), .COORD_W(12), .PITCH_W(10), .ALPHA_FMT_BIT(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference cache state and memory generation
    bit           m_valid = 1'b0;
    logic [31:0]  m_addr  = '0;
    bit           m_wide  = 1'b0;
    logic [127:0] m_data  = '0;
    logic [31:0]  gen     = 32'h1234_5678;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] blk_addr(input logic [11:0] u, input logic [11:0] v,
                                             input logic [31:0] base, input logic [9:0] pitch,
                                             input bit wide);
        logic [63:0] blk;
        blk = 64'(v / 12'd4) * 64'(pitch) + 64'(u / 12'd4);
        return 32'(64'(base) + blk * (wide ? 64'd16 : 64'd8));
    endfunction

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {a ^ gen, ~a ^ (gen * 32'h9E37_79B9)};
    endfunction

    task automatic idle_inval();
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.inval     = 1'b1;
        @(negedge clk);
        bus.inval = 1'b0;
        chk("inval_idle_ready", 128'(bus.req_ready), 128'(1));
        m_valid = 1'b0;
    endtask

    // req_stall/out_hold < 0 select random memory and decoder timing
    task automatic run_txn(input logic [11:0] u, input logic [11:0] v, input logic [31:0] base,
                           input logic [9:0] pitch, input logic [4:0] fmt, input bit inval_acc,
                           input bit inval_mid, input int req_stall, input int out_hold);
        logic [31:0]  a;
        logic [31:0]  rsp_addr;
        logic [127:0] exp_data;
        bit           wide, hit, pending, done, inval_done;
        int           n_exp, n_mem, rsp_delay, rsp_beat, stall, hold, post;
        wide  = fmt[4];
        a     = blk_addr(u, v, base, pitch, wide);
        hit   = m_valid && (m_addr == a) && (m_wide == wide) && !inval_acc;
        n_exp = hit ? 0 : (wide ? 2 : 1);
        exp_data = hit ? m_data : {(wide ? mem_word(a + 32'd8) : 64'd0), mem_word(a)};
        stall = (req_stall < 0) ? int'($urandom_range(0, 2)) : req_stall;
        hold  = (out_hold < 0) ? int'($urandom_range(0, 3)) : out_hold;
        pending = 1'b0; done = 1'b0; inval_done = 1'b0;
        n_mem = 0; rsp_delay = 0; rsp_beat = 0; post = 0; rsp_addr = '0;

        @(negedge clk);
        chk("req_ready_idle", 128'(bus.req_ready), 128'(1));
        bus.out_ready     = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.req_valid     = 1'b1;
        bus.req_u         = u;
        bus.req_v         = v;
        bus.req_base      = base;
        bus.req_pitch     = pitch;
        bus.req_format    = fmt;
        bus.inval         = inval_acc;

        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            @(negedge clk);
            bus.req_valid     = 1'b0;
            bus.inval         = 1'b0;
            bus.mem_rsp_valid = 1'b0;
            bus.mem_req_ready = 1'b0;
            bus.out_ready     = 1'b0;
            if (cyc == 0) begin
                chk("req_ready_busy", 128'(bus.req_ready), 128'(0));
                if (hit) chk("hit_latency", 128'(bus.out_valid), 128'(1));
                else     chk("miss_latency", 128'(bus.mem_req_valid), 128'(1));
            end
            if (post == 1) chk("beat1_issue", 128'(bus.mem_req_valid), 128'(1));
            if (post == 2) chk("rsp_to_out", 128'(bus.out_valid), 128'(1));
            post = 0;
            if (inval_mid && pending && !inval_done) begin
                bus.inval  = 1'b1;
                inval_done = 1'b1;
            end
            if (pending) begin
                if (rsp_delay == 0) begin
                    bus.mem_rsp_valid = 1'b1;
                    bus.mem_rsp_data  = mem_word(rsp_addr);
                    pending = 1'b0;
                    post = (rsp_beat == n_exp - 1) ? 2 : 1;
                end else begin
                    rsp_delay--;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_data  = {$urandom, $urandom};
            end
            if (bus.mem_req_valid) begin
                chk("mem_addr", 128'(bus.mem_req_addr), 128'(a + 32'(8 * n_mem)));
                if (n_mem >= n_exp) chk("extra_mem_req", 128'(n_mem + 1), 128'(n_exp));
                if (stall > 0) begin
                    stall--;
                end else begin
                    bus.mem_req_ready = 1'b1;
                    rsp_addr  = a + 32'(8 * n_mem);
                    rsp_beat  = n_mem;
                    n_mem++;
                    pending   = 1'b1;
                    rsp_delay = (req_stall < 0) ? int'($urandom_range(0, 2)) : 0;
                    stall     = (req_stall < 0) ? int'($urandom_range(0, 2)) : 0;
                end
            end
            if (bus.out_valid) begin
                chk("out_data", bus.out_data, exp_data);
                chk("out_format", 128'(bus.out_format), 128'(fmt));
                chk("out_xTexel", 128'(bus.out_xTexel), 128'(u[1:0]));
                chk("out_yTexel", 128'(bus.out_yTexel), 128'(v[1:0]));
                chk("present_req_ready", 128'(bus.req_ready), 128'(0));
                chk("beat_count", 128'(n_mem), 128'(n_exp));
                if (hold > 0) begin
                    hold--;
                end else begin
                    bus.out_ready = 1'b1;
                    done = 1'b1;
                end
            end
        end
        if (!done) chk("timeout", 128'(0), 128'(1));
        if (!hit) begin
            m_addr  = a;
            m_wide  = wide;
            m_data  = exp_data;
            m_valid = !inval_done;
        end
    endtask

    logic [11:0] u, v, pu, pv;
    logic [31:0] base, pb, a6;
    logic [9:0]  pitch, pp;
    logic [4:0]  fmt, pf;

    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_u = '0; bus.req_v = '0; bus.req_base = '0;
        bus.req_pitch = '0; bus.req_format = '0; bus.inval = 1'b0;
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 128'(bus.req_ready), 128'(0));
        chk("rst_mem_req_valid", 128'(bus.mem_req_valid), 128'(0));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_out_data", bus.out_data, 128'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 128'(bus.req_ready), 128'(1));

        // directed scenarios
        run_txn(12'd5, 12'd9, 32'h1000, 10'd4, 5'h00, 1'b0, 1'b0, 0, 0);
        run_txn(12'd6, 12'd10, 32'h1000, 10'd4, 5'h00, 1'b0, 1'b0, 0, 0);
        run_txn(12'd0, 12'd0, 32'h2000, 10'd4, 5'h10, 1'b0, 1'b0, 0, 0);
        run_txn(12'd1, 12'd2, 32'h2000, 10'd4, 5'h10, 1'b0, 1'b0, 0, 5);
        run_txn(12'd3, 12'd3, 32'h2000, 10'd4, 5'h13, 1'b0, 1'b0, 0, 0);
        run_txn(12'd8, 12'd8, 32'h3000, 10'd7, 5'h00, 1'b0, 1'b1, 0, 0);
        run_txn(12'd8, 12'd8, 32'h3000, 10'd7, 5'h00, 1'b0, 1'b0, 0, 0);
        run_txn(12'd8, 12'd8, 32'h3000, 10'd7, 5'h10, 1'b0, 1'b0, 0, 0);
        run_txn(12'd9, 12'd9, 32'h3000, 10'd7, 5'h10, 1'b1, 1'b0, 0, 0);

        // stalled memory request, then reset during the fetch
        a6 = blk_addr(12'd20, 12'd4, 32'h4000, 10'd9, 1'b0);
        @(negedge clk);
        bus.out_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_req_ready = 1'b0;
        bus.req_u = 12'd20; bus.req_v = 12'd4; bus.req_base = 32'h4000;
        bus.req_pitch = 10'd9; bus.req_format = 5'h00; bus.req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            chk("stall_valid", 128'(bus.mem_req_valid), 128'(1));
            chk("stall_addr", 128'(bus.mem_req_addr), 128'(a6));
            bus.mem_req_ready = (i == 3);
        end
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_req_ready", 128'(bus.req_ready), 128'(0));
        chk("midrst_mem_req_valid", 128'(bus.mem_req_valid), 128'(0));
        chk("midrst_mem_req_addr", 128'(bus.mem_req_addr), 128'(0));
        chk("midrst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("midrst_out_data", bus.out_data, 128'(0));
        chk("midrst_out_misc", 128'({bus.out_format, bus.out_xTexel, bus.out_yTexel}), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        m_valid = 1'b0;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        chk("late_rsp_ignored", 128'(bus.out_valid), 128'(0));

        // reset must drop a valid cache entry
        run_txn(12'd20, 12'd4, 32'h4000, 10'd9, 5'h00, 1'b0, 1'b0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_valid = 1'b0;
        run_txn(12'd21, 12'd5, 32'h4000, 10'd9, 5'h00, 1'b0, 1'b0, 0, 0);

        // randomised traffic with frequent same-block reuse
        pu = 12'd21; pv = 12'd5; pb = 32'h4000; pp = 10'd9; pf = 5'h00;
        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 2) != 0) begin
                u = {pu[11:2], 2'($urandom)};
                v = {pv[11:2], 2'($urandom)};
                base = pb; pitch = pp;
                fmt = {($urandom_range(0, 5) == 0) ? ~pf[4] : pf[4], 4'($urandom)};
            end else begin
                u = 12'($urandom); v = 12'($urandom);
                base = {29'($urandom), 3'b000};
                pitch = 10'($urandom); fmt = 5'($urandom);
            end
            if ($urandom_range(0, 7) == 0) gen = $urandom;
            if ($urandom_range(0, 9) == 0) idle_inval();
            run_txn(u, v, base, pitch, fmt, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 7) == 0, -1, -1);
            pu = u; pv = v; pb = base; pp = pitch; pf = fmt;
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
